// File: rtl/fic_pkg.sv
// Shared fetch/decode definitions: the fetch FSM state encoding and the HALT opcode field.
package fic_pkg;

    localparam int unsigned FIC_OP_MSB = 4;
    localparam logic [FIC_OP_MSB-1:0] FIC_HALT_OP = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory address/data plus the IR handshake towards decode.
interface fetch_unit_if #(
    parameter int unsigned W = 16
);
    logic         start;
    logic         branch_taken;
    logic [W-1:0] branch_target;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_data;
    logic [W-1:0] ir;
    logic [W-1:0] ir_pc;
    logic         ir_valid;
    logic         ir_ready;
    logic         halted;

    modport master (
        input  start, branch_taken, branch_target, imem_data, ir_ready,
        output imem_addr, ir, ir_pc, ir_valid, halted
    );

    modport slave (
        output start, branch_taken, branch_target, imem_data, ir_ready,
        input  imem_addr, ir, ir_pc, ir_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, captures memory words into the IR and
// hands them to decode over valid/ready; honours branch redirects and stops on HALT.
module fetch_unit
    import fic_pkg::*;
#(
    parameter int unsigned            W        = 16,
    parameter logic [W-1:0]           RESET_PC = '0,
    parameter int unsigned            OP_MSB   = FIC_OP_MSB,
    parameter logic [OP_MSB-1:0]      HALT_OP  = FIC_HALT_OP
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_t      r_state;
    logic [W-1:0]      r_pc;
    logic [W-1:0]      r_ir;
    logic [W-1:0]      r_ir_pc;
    logic              r_ir_valid;
    logic              r_halted;

    logic              w_take;
    logic              w_is_halt;

    // The IR may be refilled when empty or when decode consumes it this cycle.
    assign w_take    = !r_ir_valid || bus.ir_ready;
    assign w_is_halt = (bus.imem_data[W-1 -: OP_MSB] == HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.branch_taken) begin
                        r_pc       <= bus.branch_target;
                        r_ir_valid <= 1'b0;
                    end else if (w_take) begin
                        r_ir       <= bus.imem_data;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        // A HALT word parks the PC on its own address.
                        if (w_is_halt) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (bus.ir_ready) begin
                        r_ir_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.ir        = r_ir;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural combinational instruction memory.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [15:0] mem [0:65535];

    fetch_unit_if #(.W(16)) bus ();

    fetch_unit #(
        .W        (16),
        .RESET_PC (16'h0000),
        .OP_MSB   (4),
        .HALT_OP  (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 16'h0000;
        bus.ir_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_fetch();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.imem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 0000", bus.imem_addr);
        end
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b0 || bus.ir !== 16'h0000) begin
            failures++;
            $display("FAIL reset_flags: got valid=%b halted=%b ir=%h expected 0 0 0000",
                     bus.ir_valid, bus.halted, bus.ir);
        end
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.imem_addr !== 16'h0000 || bus.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got addr=%h valid=%b expected 0000 0",
                     bus.imem_addr, bus.ir_valid);
        end
    endtask

    task automatic test_sequence();
        logic [15:0] exp_ir [3];
        exp_ir[0] = 16'hA001;
        exp_ir[1] = 16'hB002;
        exp_ir[2] = 16'hC003;
        do_reset();
        bus.ir_ready = 1'b1;
        start_fetch();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ir !== exp_ir[i] || bus.ir_pc !== 16'(i) || bus.ir_valid !== 1'b1
                || bus.imem_addr !== 16'(i + 1)) begin
                failures++;
                $display("FAIL seq_%0d: got ir=%h ir_pc=%h valid=%b addr=%h expected %h %h 1 %h",
                         i, bus.ir, bus.ir_pc, bus.ir_valid, bus.imem_addr,
                         exp_ir[i], 16'(i), 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall_and_branch();
        do_reset();
        start_fetch();
        // ir_ready=0 but IR empty: first word is still captured
        tick();
        checks++;
        if (bus.ir !== 16'hA001 || bus.ir_valid !== 1'b1 || bus.imem_addr !== 16'h0001) begin
            failures++;
            $display("FAIL first_capture: got ir=%h valid=%b addr=%h expected A001 1 0001",
                     bus.ir, bus.ir_valid, bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ir !== 16'hA001 || bus.ir_pc !== 16'h0000 || bus.imem_addr !== 16'h0001
                || bus.ir_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_%0d: got ir=%h ir_pc=%h addr=%h valid=%b expected A001 0000 0001 1",
                         i, bus.ir, bus.ir_pc, bus.imem_addr, bus.ir_valid);
            end
        end
        bus.ir_ready = 1'b1;
        tick();
        checks++;
        if (bus.ir !== 16'hB002 || bus.ir_pc !== 16'h0001 || bus.imem_addr !== 16'h0002) begin
            failures++;
            $display("FAIL stall_release: got ir=%h ir_pc=%h addr=%h expected B002 0001 0002",
                     bus.ir, bus.ir_pc, bus.imem_addr);
        end
        // branch with decode not ready still flushes
        bus.ir_ready      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0040;
        tick();
        bus.branch_taken  = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.imem_addr !== 16'h0040) begin
            failures++;
            $display("FAIL branch_flush: got valid=%b addr=%h expected 0 0040",
                     bus.ir_valid, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.ir !== 16'h7777 || bus.ir_pc !== 16'h0040 || bus.ir_valid !== 1'b1
            || bus.imem_addr !== 16'h0041) begin
            failures++;
            $display("FAIL branch_land: got ir=%h ir_pc=%h valid=%b addr=%h expected 7777 0040 1 0041",
                     bus.ir, bus.ir_pc, bus.ir_valid, bus.imem_addr);
        end
    endtask

    task automatic test_halt();
        mem[3] = 16'hF000;
        do_reset();
        bus.ir_ready = 1'b1;
        start_fetch();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.ir !== 16'hF000 || bus.halted !== 1'b1 || bus.imem_addr !== 16'h0003
            || bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h0003) begin
            failures++;
            $display("FAIL halt_capture: got ir=%h halted=%b addr=%h valid=%b ir_pc=%h expected F000 1 0003 1 0003",
                     bus.ir, bus.halted, bus.imem_addr, bus.ir_valid, bus.ir_pc);
        end
        bus.ir_ready      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0040;
        bus.start         = 1'b1;
        tick();
        tick();
        bus.branch_taken  = 1'b0;
        bus.start         = 1'b0;
        checks++;
        if (bus.imem_addr !== 16'h0003 || bus.halted !== 1'b1 || bus.ir !== 16'hF000
            || bus.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_ignore: got addr=%h halted=%b ir=%h valid=%b expected 0003 1 F000 1",
                     bus.imem_addr, bus.halted, bus.ir, bus.ir_valid);
        end
        bus.ir_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.ir !== 16'hF000 || bus.imem_addr !== 16'h0003
            || bus.halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_drain: got valid=%b ir=%h addr=%h halted=%b expected 0 F000 0003 1",
                     bus.ir_valid, bus.ir, bus.imem_addr, bus.halted);
        end
        mem[3] = 16'hD004;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        bus.ir_ready = 1'b1;
        start_fetch();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'hFFFF;
        tick();
        bus.branch_taken  = 1'b0;
        tick();
        checks++;
        if (bus.ir !== 16'h1234 || bus.ir_pc !== 16'hFFFF || bus.imem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL pc_wrap: got ir=%h ir_pc=%h addr=%h expected 1234 FFFF 0000",
                     bus.ir, bus.ir_pc, bus.imem_addr);
        end
        tick();
        bus.ir_ready = 1'b0;
        tick();
        checks++;
        if (bus.ir !== 16'hA001 || bus.imem_addr !== 16'h0001 || bus.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_next: got ir=%h addr=%h valid=%b expected A001 0001 1",
                     bus.ir, bus.imem_addr, bus.ir_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.imem_addr !== 16'h0000 || bus.ir !== 16'h0000 || bus.ir_pc !== 16'h0000
            || bus.ir_valid !== 1'b0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL midstall_reset: got addr=%h ir=%h ir_pc=%h valid=%b halted=%b expected 0000 0000 0000 0 0",
                     bus.imem_addr, bus.ir, bus.ir_pc, bus.ir_valid, bus.halted);
        end
        bus.ir_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.imem_addr !== 16'h0000 || bus.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_to_idle: got addr=%h valid=%b expected 0000 0",
                     bus.imem_addr, bus.ir_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'h1000;
        mem[0]       = 16'hA001;
        mem[1]       = 16'hB002;
        mem[2]       = 16'hC003;
        mem[3]       = 16'hD004;
        mem[16'h40]  = 16'h7777;
        mem[16'hFFFF] = 16'h1234;

        test_reset();
        test_sequence();
        test_stall_and_branch();
        test_halt();
        test_wrap_and_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
